spi_master_arbiter: RTL and testbench



---
 rtl/spi_master_arbiter.sv | 130 +++++++++++++
 tb/tb_spi_master_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master_core among NUM_REQ requesters.
// Completion is taken from the core's chip-select bus; stalled transfers are aborted with an error.
module spi_master_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CHANNEL   = 8,
  parameter int REG_WIDTH = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CHANNEL-1:0]   req_channel,
  input  logic [NUM_REQ*REG_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [REG_WIDTH-1:0]         resp_rdata,
  output logic                         resp_err,
  output logic                         core_valid,
  output logic [CHANNEL-1:0]           core_channel,
  output logic [REG_WIDTH-1:0]         core_wdata,
  input  logic                         core_ready,
  input  logic [REG_WIDTH-1:0]         core_rdata,
  input  logic [CHANNEL-1:0]           core_cs
);

  localparam int          GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TC = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t              r_state;
  logic [GW-1:0]       r_last;
  logic [GW-1:0]       r_gnt;
  logic [15:0]         r_cnt;
  logic                r_zero;

  logic                w_found;
  logic [GW-1:0]       w_gnt;
  logic [CHANNEL-1:0]  w_ch;
  logic [REG_WIDTH-1:0] w_wd;
  logic                w_tc;
  logic                w_done;

  // Search upward from last_grant+1, wrapping, so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = GW'(idx);
      end
    end
  end

  assign w_ch   = req_channel[w_gnt*CHANNEL +: CHANNEL];
  assign w_wd   = req_wdata[w_gnt*REG_WIDTH +: REG_WIDTH];
  assign w_tc   = (r_cnt == TC);
  assign w_done = &core_cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= GW'(NUM_REQ - 1);
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_zero       <= 1'b0;
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      core_valid   <= 1'b0;
      core_channel <= '0;
      core_wdata   <= '0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            core_channel     <= w_ch;
            core_wdata       <= w_wd;
            req_ready[w_gnt] <= 1'b1;
            r_gnt            <= w_gnt;
            r_cnt            <= '0;
            // A zero channel never pulls CS low, so it would look like instant completion.
            r_zero           <= (w_ch == '0);
            core_valid       <= (w_ch != '0);
            r_state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_zero || w_tc) begin
            core_valid        <= 1'b0;
            resp_valid[r_gnt] <= 1'b1;
            resp_err          <= 1'b1;
            resp_rdata        <= '0;
            r_last            <= r_gnt;
            r_state           <= S_IDLE;
          end else if (core_ready) begin
            core_valid <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 16'd1;
          // Completion outranks a simultaneous timeout.
          if (w_done) begin
            resp_valid[r_gnt] <= 1'b1;
            resp_err          <= 1'b0;
            resp_rdata        <= core_rdata;
            r_last            <= r_gnt;
            r_state           <= S_IDLE;
          end else if (w_tc) begin
            resp_valid[r_gnt] <= 1'b1;
            resp_err          <= 1'b1;
            resp_rdata        <= '0;
            r_last            <= r_gnt;
            r_state           <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: behavioural core model returning ~wdata, grant/response scoreboards,
// a vector table of single transfers and hand sequences for round-robin, back-to-back, timeout and reset.
module tb_spi_master_arbiter;
  localparam int NR = 4;
  localparam int CH = 8;
  localparam int RW = 16;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*CH-1:0] req_channel;
  logic [NR*RW-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    resp_valid;
  logic [RW-1:0]    resp_rdata;
  logic             resp_err;
  logic             core_valid;
  logic [CH-1:0]    core_channel;
  logic [RW-1:0]    core_wdata;
  logic             core_ready;
  logic [RW-1:0]    core_rdata;
  logic [CH-1:0]    core_cs;

  spi_master_arbiter #(.NUM_REQ(NR), .CHANNEL(CH), .REG_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_channel(req_channel), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .core_valid(core_valid), .core_channel(core_channel), .core_wdata(core_wdata),
    .core_ready(core_ready), .core_rdata(core_rdata), .core_cs(core_cs)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int cv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Core model: accepts wr_valid one cycle later, drops CS with wr_ready, returns ~wdata.
  logic    core_ack_en = 1'b1;
  int      core_len    = 3;
  logic    m_busy;
  int      m_cnt;
  logic [RW-1:0] m_wd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready <= 1'b0; core_cs <= '1; core_rdata <= '0;
      m_busy <= 1'b0; m_cnt <= 0; m_wd <= '0;
    end else begin
      core_ready <= 1'b0;
      if (!m_busy) begin
        if (core_valid && core_ack_en) begin
          core_ready <= 1'b1; core_cs <= ~core_channel; m_wd <= core_wdata;
          m_busy <= 1'b1; m_cnt <= core_len;
        end
      end else if (m_cnt == 0) begin
        core_cs <= '1; core_rdata <= ~m_wd; m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct { int id; logic [CH-1:0] ch; logic [RW-1:0] wd; } gnt_t;
  typedef struct { int id; logic [RW-1:0] rd; logic err; } rsp_t;
  gnt_t gnt_q[$];
  rsp_t exp_q[$];
  logic [NR-1:0] prev_resp = '0;

  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    if (!rst_n) begin
      gnt_q.delete(); exp_q.delete(); prev_resp = '0;
    end else begin
      if (core_valid) cv_cnt++;
      if (|req_ready) begin
        check("ready_onehot", 32'($onehot(req_ready)), 1);
        if (gnt_q.size() == 0) check("unexpected_grant", 32'(req_ready), 0);
        else begin
          g = gnt_q.pop_front();
          check("grant_id", 32'(req_ready), 32'(1 << g.id));
          check("core_channel", 32'(core_channel), 32'(g.ch));
          check("core_wdata", 32'(core_wdata), 32'(g.wd));
        end
      end
      if (|resp_valid) begin
        check("resp_onehot", 32'($onehot(resp_valid)), 1);
        check("resp_single_cycle", 32'(|prev_resp), 0);
        if (exp_q.size() == 0) check("unexpected_resp", 32'(resp_valid), 0);
        else begin
          r = exp_q.pop_front();
          check("resp_id", 32'(resp_valid), 32'(1 << r.id));
          check("resp_rdata", 32'(resp_rdata), 32'(r.rd));
          check("resp_err", 32'(resp_err), 32'(r.err));
        end
      end
      prev_resp = resp_valid;
    end
  end

  task automatic drive_req(input int id, input logic [CH-1:0] ch, input logic [RW-1:0] wd);
    req_channel[id*CH +: CH] = ch;
    req_wdata[id*RW +: RW]   = wd;
    req_valid[id]            = 1'b1;
  endtask

  task automatic wait_ready(input int id, output int at);
    bit ok = 1'b0;
    at = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1'b1; at = cyc; end
    end
    if (!ok) check($sformatf("ready%0d_timeout", id), 0, 1);
  endtask

  task automatic wait_resp(input int id, output int at);
    bit ok = 1'b0;
    at = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (resp_valid[id]) begin ok = 1'b1; at = cyc; end
    end
    if (!ok) check($sformatf("resp%0d_timeout", id), 0, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 500 && (exp_q.size() + gnt_q.size()) != 0; i++) @(negedge clk);
    check(name, 32'(exp_q.size() + gnt_q.size()), 0);
  endtask

  task automatic wait_grants(input int n, input string name);
    int seen = 0;
    for (int i = 0; i < 500 && seen < n; i++) begin
      @(negedge clk);
      if (|req_ready) seen++;
    end
    check(name, 32'(seen), 32'(n));
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_req_ready"},    32'(req_ready), 0);
    check({p, "_resp_valid"},   32'(resp_valid), 0);
    check({p, "_resp_err"},     32'(resp_err), 0);
    check({p, "_resp_rdata"},   32'(resp_rdata), 0);
    check({p, "_core_valid"},   32'(core_valid), 0);
    check({p, "_core_channel"}, 32'(core_channel), 0);
    check({p, "_core_wdata"},   32'(core_wdata), 0);
  endtask

  typedef struct {
    int id; logic [CH-1:0] ch; logic [RW-1:0] wd;
    logic [RW-1:0] exp_rd; logic exp_err;
  } vec_t;

  vec_t vecs[6];
  logic [CH-1:0] rr_ch[4];
  logic [RW-1:0] rr_wd[4];
  int ta, tb, c0;

  initial begin
    vecs[0] = '{1, 8'h04, 16'hA55A, 16'h5AA5, 1'b0};
    vecs[1] = '{0, 8'h01, 16'h1234, 16'hEDCB, 1'b0};
    vecs[2] = '{3, 8'h00, 16'hBEEF, 16'h0000, 1'b1};
    vecs[3] = '{2, 8'h80, 16'hFFFF, 16'h0000, 1'b0};
    vecs[4] = '{3, 8'h10, 16'h0000, 16'hFFFF, 1'b0};
    vecs[5] = '{1, 8'h00, 16'h0F0F, 16'h0000, 1'b1};
    rr_ch = '{8'h01, 8'h02, 8'h20, 8'h40};
    rr_wd = '{16'h0101, 16'h1212, 16'h2323, 16'h3434};

    req_valid = '0; req_channel = '0; req_wdata = '0; rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (3) begin @(negedge clk); check_reset_outputs("rst_init"); end
    rst_n = 1'b1;

    // Single transfers from the vector table.
    for (int v = 0; v < 6; v++) begin
      gnt_q.push_back('{vecs[v].id, vecs[v].ch, vecs[v].wd});
      exp_q.push_back('{vecs[v].id, vecs[v].exp_rd, vecs[v].exp_err});
      drive_req(vecs[v].id, vecs[v].ch, vecs[v].wd);
      wait_ready(vecs[v].id, ta);
      check($sformatf("vec%0d_core_valid_with_ready", v), 32'(core_valid), 32'(vecs[v].ch != '0));
      req_valid[vecs[v].id] = 1'b0;
      wait_drain($sformatf("vec%0d_drain", v));
    end

    // Round-robin from reset with all four requesters held valid.
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gnt_q.push_back('{i % 4, rr_ch[i % 4], rr_wd[i % 4]});
      exp_q.push_back('{i % 4, ~rr_wd[i % 4], 1'b0});
    end
    for (int i = 0; i < 4; i++) drive_req(i, rr_ch[i], rr_wd[i]);
    wait_grants(5, "rr_grant_count");
    req_valid = '0;
    wait_drain("rr_drain");

    // Only req0 and req2: last grant was 0, so 2,0,2,0.
    for (int i = 0; i < 4; i++) begin
      int id;
      id = (i % 2 == 0) ? 2 : 0;
      gnt_q.push_back('{id, rr_ch[id], rr_wd[id]});
      exp_q.push_back('{id, ~rr_wd[id], 1'b0});
    end
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    wait_grants(4, "alt_grant_count");
    req_valid = '0;
    wait_drain("alt_drain");

    // Back-to-back on req2: next core_valid in the cycle right after resp_valid.
    for (int i = 0; i < 2; i++) begin
      gnt_q.push_back('{2, 8'h08, 16'h5555});
      exp_q.push_back('{2, 16'hAAAA, 1'b0});
    end
    drive_req(2, 8'h08, 16'h5555);
    wait_resp(2, tb);
    @(negedge clk);
    check("b2b_core_valid", 32'(core_valid), 1);
    check("b2b_req_ready", 32'(req_ready[2]), 1);
    req_valid[2] = 1'b0;
    wait_drain("b2b_drain");

    // Zero channel: error one cycle after the accept, core never requested.
    gnt_q.push_back('{3, 8'h00, 16'hBEEF});
    exp_q.push_back('{3, 16'h0000, 1'b1});
    c0 = cv_cnt;
    drive_req(3, 8'h00, 16'hBEEF);
    wait_ready(3, ta);
    req_valid[3] = 1'b0;
    wait_resp(3, tb);
    check("zero_latency", 32'(tb - ta), 1);
    check("zero_no_core_valid", 32'(cv_cnt - c0), 0);
    wait_drain("zero_drain");

    // Timeout: core never acknowledges.
    core_ack_en = 1'b0;
    gnt_q.push_back('{1, 8'h02, 16'h1111});
    exp_q.push_back('{1, 16'h0000, 1'b1});
    drive_req(1, 8'h02, 16'h1111);
    wait_ready(1, ta);
    req_valid[1] = 1'b0;
    wait_resp(1, tb);
    check("timeout_latency", 32'(tb - ta), 64);
    @(negedge clk);
    check("timeout_core_valid_low", 32'(core_valid), 0);
    core_ack_en = 1'b1;
    wait_drain("timeout_drain");

    // Reset in the middle of a long transfer.
    core_len = 20;
    gnt_q.push_back('{2, 8'h08, 16'h7777});
    drive_req(2, 8'h08, 16'h7777);
    wait_ready(2, ta);
    req_valid[2] = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_core_valid_low", 32'(core_valid), 0);
    check("busy_cs_low", 32'(&core_cs), 0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (3) begin @(negedge clk); check_reset_outputs("rst_hold"); end
    rst_n = 1'b1;
    core_len = 3;
    gnt_q.push_back('{0, 8'h01, 16'h0A0A});
    gnt_q.push_back('{3, 8'h40, 16'h0B0B});
    exp_q.push_back('{0, 16'hF5F5, 1'b0});
    exp_q.push_back('{3, 16'hF4F4, 1'b0});
    drive_req(0, 8'h01, 16'h0A0A);
    drive_req(3, 8'h40, 16'h0B0B);
    wait_ready(0, ta);
    req_valid[0] = 1'b0;
    wait_ready(3, tb);
    req_valid[3] = 1'b0;
    wait_drain("post_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
